// File: rtl/vga_pkg.sv
// Shared VGA timing constants, raster bus type and test-pattern colour table.
package vga_pkg;
  localparam int CNT_W = 11;
  localparam int RGB_B = 12;

  localparam int H_ACTIVE_DEF = 800;
  localparam int H_FP_DEF     = 40;
  localparam int H_SYNC_DEF   = 128;
  localparam int H_BP_DEF     = 88;
  localparam int V_ACTIVE_DEF = 600;
  localparam int V_FP_DEF     = 1;
  localparam int V_SYNC_DEF   = 4;
  localparam int V_BP_DEF     = 23;
  localparam bit SYNC_POL_DEF = 1'b1;

  typedef struct packed {
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hblnk;
    logic             vblnk;
    logic             hsync;
    logic             vsync;
  } vga_t;

  // Index 0 is the leftmost bar.
  localparam logic [7:0][RGB_B-1:0] BAR_RGB = {
    12'h000, 12'h00F, 12'hF00, 12'hF0F, 12'h0F0, 12'h0FF, 12'hFF0, 12'hFFF
  };
endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with blank/sync decoded from the next count.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE   = H_ACTIVE_DEF,
  parameter int FP       = H_FP_DEF,
  parameter int SYNC     = H_SYNC_DEF,
  parameter int BP       = H_BP_DEF,
  parameter bit SYNC_POL = SYNC_POL_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step_i,
  output logic [CNT_W-1:0] count_o,
  output logic             blank_o,
  output logic             sync_o,
  output logic             wrap_o
);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(ACTIVE + FP + SYNC + BP - 1);
  localparam logic [CNT_W-1:0] ACT    = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_S = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_E = CNT_W'(ACTIVE + FP + SYNC);

  logic [CNT_W-1:0] count_q, count_d;
  logic             blank_q, blank_d;
  logic             sync_q, sync_d;

  // Combinational so the next axis can step on the same edge this one wraps.
  assign wrap_o = step_i && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (step_i) count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    blank_d = (count_d >= ACT);
    sync_d  = ((count_d >= SYNC_S) && (count_d < SYNC_E)) ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      blank_q <= 1'b0;
      sync_q  <= ~SYNC_POL;
    end else begin
      count_q <= count_d;
      blank_q <= blank_d;
      sync_q  <= sync_d;
    end
  end

  assign count_o = count_q;
  assign blank_o = blank_q;
  assign sync_o  = sync_q;
endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster source with frame strobe/counter.
// VGA_TIMING_TEST_PATTERN_EN adds a registered 8-bar colour output rgb_o.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit SYNC_POL = SYNC_POL_DEF,
  parameter int FRAME_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output vga_t               vga_out,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
`ifdef VGA_TIMING_TEST_PATTERN_EN
  ,
  output logic [RGB_B-1:0]   rgb_o
`endif
);
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_blnk, v_blnk, h_sync, v_sync;
  logic             h_wrap, v_wrap, v_step;

  assign v_step = en & h_wrap;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .SYNC_POL(SYNC_POL)
  ) u_h (
    .clk(clk), .rst_n(rst_n), .step_i(en),
    .count_o(h_cnt), .blank_o(h_blnk), .sync_o(h_sync), .wrap_o(h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .SYNC_POL(SYNC_POL)
  ) u_v (
    .clk(clk), .rst_n(rst_n), .step_i(v_step),
    .count_o(v_cnt), .blank_o(v_blnk), .sync_o(v_sync), .wrap_o(v_wrap)
  );

  // v_wrap marks the edge on which the raster returns to (0,0).
  logic               frame_start_q, frame_start_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_start_d = v_wrap;
    frame_cnt_d   = v_wrap ? frame_cnt_q + 1'b1 : frame_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign vga_out     = '{hcount: h_cnt, vcount: v_cnt, hblnk: h_blnk,
                         vblnk: v_blnk, hsync: h_sync, vsync: v_sync};
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

`ifdef VGA_TIMING_TEST_PATTERN_EN
  localparam int               BAR_W   = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
  localparam logic [CNT_W-1:0] BAR_W_C = CNT_W'(BAR_W);
  localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C = CNT_W'(V_ACTIVE);

  logic [CNT_W-1:0] h_nxt, v_nxt, bar;
  logic [RGB_B-1:0] rgb_q, rgb_d;

  // Colour is decoded from the next position so it lands with the counts.
  always_comb begin
    h_nxt = h_cnt;
    if (en) h_nxt = h_wrap ? '0 : h_cnt + 1'b1;
    v_nxt = v_cnt;
    if (v_step) v_nxt = v_wrap ? '0 : v_cnt + 1'b1;
    bar = h_nxt / BAR_W_C;
    if (bar > CNT_W'(7)) bar = CNT_W'(7);
    rgb_d = ((h_nxt >= H_ACT_C) || (v_nxt >= V_ACT_C)) ? '0 : BAR_RGB[bar[2:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rgb_q <= '0;
    else        rgb_q <= rgb_d;
  end

  assign rgb_o = rgb_q;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: a shrunk-timing instance for whole-frame behaviour and a
// default 800x600 instance for line timing, both checked against an arithmetic raster model.
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam int SHA = 16, SHF = 2, SHS = 4, SHB = 3;
  localparam int SVA = 6,  SVF = 1, SVS = 2, SVB = 2;
  localparam int SHT = SHA + SHF + SHS + SHB;   // 25
  localparam int SVT = SVA + SVF + SVS + SVB;   // 11
  localparam int SFT = SHT * SVT;               // 275
  localparam int FHT = 1056, FVT = 628;

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  vga_t vo_s, vo_f;
  logic fs_s, fs_f;
  logic [1:0]  fc_s;
  logic [15:0] fc_f;
`ifdef VGA_TIMING_TEST_PATTERN_EN
  logic [RGB_B-1:0] rgb_s, rgb_f;
`endif

  int     errs = 0, checks = 0;
  longint t = 0;     // enabled steps since last reset
  bit     stp = 0;   // last edge advanced the raster

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .SYNC_POL(1'b1), .FRAME_W(2)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .en(en), .vga_out(vo_s),
    .frame_start(fs_s), .frame_cnt(fc_s)
`ifdef VGA_TIMING_TEST_PATTERN_EN
    , .rgb_o(rgb_s)
`endif
  );

  vga_timing_gen dut_f (
    .clk(clk), .rst_n(rst_n), .en(en), .vga_out(vo_f),
    .frame_start(fs_f), .frame_cnt(fc_f)
`ifdef VGA_TIMING_TEST_PATTERN_EN
    , .rgb_o(rgb_f)
`endif
  );

  function automatic vga_t ref_vga(longint tt, int ht, int vt, int ha, int hf, int hs,
                                   int va, int vf, int vs);
    vga_t r;
    int h, v;
    h = int'(tt % longint'(ht));
    v = int'((tt / longint'(ht)) % longint'(vt));
    r.hcount = 11'(h);
    r.vcount = 11'(v);
    r.hblnk  = (h >= ha);
    r.vblnk  = (v >= va);
    r.hsync  = (h >= ha + hf) && (h < ha + hf + hs);
    r.vsync  = (v >= va + vf) && (v < va + vf + vs);
    return r;
  endfunction

  function automatic vga_t ref_s(longint tt);
    return ref_vga(tt, SHT, SVT, SHA, SHF, SHS, SVA, SVF, SVS);
  endfunction

  function automatic vga_t ref_f(longint tt);
    return ref_vga(tt, FHT, FVT, 800, 40, 128, 600, 1, 4);
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin t = 0; stp = 0; end
    else if (en) begin t++; stp = 1; end
    else stp = 0;
    #1;
  endtask

  // Leaves reset released mid-cycle with en=1; the next edge steps to hcount 1.
  task automatic reset_dut();
    #2 rst_n = 1'b0; en = 1'b0; t = 0; stp = 0;
    tick();
    #3 rst_n = 1'b1; en = 1'b1;
  endtask

  task automatic test_reset();
    vga_t rv;
    rv = '{hcount: '0, vcount: '0, hblnk: 1'b0, vblnk: 1'b0, hsync: 1'b0, vsync: 1'b0};
    rst_n = 1'b0; en = 1'b0;
    tick(); tick();
    checks++;
    if ({vo_s, fs_s, fc_s} !== {rv, 1'b0, 2'b0}) begin
      errs++; $display("FAIL reset_s: got %h/%b/%0d want %h/0/0", vo_s, fs_s, fc_s, rv);
    end
    checks++;
    if ({vo_f, fs_f, fc_f} !== {rv, 1'b0, 16'd0}) begin
      errs++; $display("FAIL reset_f: got %h/%b/%0d want %h/0/0", vo_f, fs_f, fc_f, rv);
    end
    #3 rst_n = 1'b1; en = 1'b1;
    repeat (37) tick();
    checks++;
    if (vo_s !== ref_s(t)) begin
      errs++; $display("FAIL pre_reset_run: got %h want %h", vo_s, ref_s(t));
    end
    #3 rst_n = 1'b0;
    #1;
    t = 0; stp = 0;
    checks++;
    if ({vo_s, fs_s, fc_s, vo_f, fs_f, fc_f} !== {rv, 1'b0, 2'b0, rv, 1'b0, 16'd0}) begin
      errs++; $display("FAIL reset_async: got %h/%h fs %b%b", vo_s, vo_f, fs_s, fs_f);
    end
    tick();
    #3 rst_n = 1'b1;
    tick();
    checks++;
    if (vo_s.hcount !== 11'd1 || vo_f.hcount !== 11'd1 || fs_s !== 1'b0) begin
      errs++; $display("FAIL reset_release: hcount %0d/%0d fs %b want 1/1/0",
                       vo_s.hcount, vo_f.hcount, fs_s);
    end
  endtask

  task automatic test_line();
    int rise_h = -1, hs_first = -1, hs_last = -1, hs_cnt = 0, period = -1;
    longint z0 = -1;
    bit prev_hb = 1'b0;
    reset_dut();
    for (int i = 0; i < 2 * FHT + 5; i++) begin
      tick();
      if (vo_f.hblnk && !prev_hb && rise_h < 0) rise_h = int'(vo_f.hcount);
      prev_hb = vo_f.hblnk;
      if (vo_f.vcount == 11'd0 && vo_f.hsync) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(vo_f.hcount);
        hs_last = int'(vo_f.hcount);
      end
      if (vo_f.hcount == 11'd0) begin
        if (z0 >= 0 && period < 0) period = int'(t - z0);
        z0 = t;
      end
    end
    checks++;
    if (rise_h != 800) begin errs++; $display("FAIL hblnk_rise: got %0d want 800", rise_h); end
    checks++;
    if (hs_first != 840 || hs_last != 967) begin
      errs++; $display("FAIL hsync_window: got %0d..%0d want 840..967", hs_first, hs_last);
    end
    checks++;
    if (hs_cnt != 128) begin errs++; $display("FAIL hsync_width: got %0d want 128", hs_cnt); end
    checks++;
    if (period != FHT) begin errs++; $display("FAIL line_period: got %0d want %0d", period, FHT); end
    checks++;
    if (vo_f.vcount !== 11'd2 || vo_f.vblnk !== 1'b0 || vo_f.vsync !== 1'b0) begin
      errs++; $display("FAIL line_vcount: got v=%0d vb=%b vs=%b want 2/0/0",
                       vo_f.vcount, vo_f.vblnk, vo_f.vsync);
    end
  endtask

  task automatic test_frame();
    int last = 0, n = 0;
    bit prev_vb = 1'b0;
    reset_dut();
    for (int e = 1; e <= 3 * SFT + 10; e++) begin
      tick();
      if (vo_s.vblnk !== prev_vb) begin
        checks++;
        if (vo_s.hcount !== 11'd0) begin
          errs++; $display("FAIL vblnk_align: changed at hcount %0d want 0", vo_s.hcount);
        end
      end
      prev_vb = vo_s.vblnk;
      checks++;
      if (vo_s.vblnk !== (vo_s.vcount >= 11'(SVA)) ||
          vo_s.vsync !== (vo_s.vcount >= 11'(SVA + SVF) && vo_s.vcount < 11'(SVA + SVF + SVS))) begin
        errs++; $display("FAIL v_flags: v=%0d vb=%b vs=%b", vo_s.vcount, vo_s.vblnk, vo_s.vsync);
      end
      if (fs_s) begin
        n++;
        checks++;
        if (e - last != SFT || vo_s.hcount !== 11'd0 || vo_s.vcount !== 11'd0) begin
          errs++; $display("FAIL frame_period: gap %0d at (%0d,%0d) want %0d at (0,0)",
                           e - last, vo_s.hcount, vo_s.vcount, SFT);
        end
        checks++;
        if (fc_s !== 2'(n)) begin
          errs++; $display("FAIL frame_cnt: got %0d want %0d", fc_s, n % 4);
        end
        last = e;
      end
    end
    checks++;
    if (n != 3) begin errs++; $display("FAIL frame_strobes: got %0d want 3", n); end
  endtask

  task automatic test_random();
    vga_t es, ef;
    logic fs_e;
    reset_dut();
    for (int i = 0; i < 3000; i++) begin
      tick();
      es   = ref_s(t);
      ef   = ref_f(t);
      fs_e = stp && (t % SFT == 0) && (t != 0);
      checks++;
      if ({vo_s, fs_s, fc_s} !== {es, fs_e, 2'((t / SFT) % 4)}) begin
        errs++; $display("FAIL random_s: t=%0d got %h/%b/%0d want %h/%b/%0d",
                         t, vo_s, fs_s, fc_s, es, fs_e, (t / SFT) % 4);
      end
      checks++;
      if ({vo_f, fs_f, fc_f} !== {ef, 1'b0, 16'd0}) begin
        errs++; $display("FAIL random_f: t=%0d got %h/%b/%0d want %h/0/0", t, vo_f, fs_f, fc_f, ef);
      end
      en = ($urandom_range(0, 9) < 8);
    end
  endtask

  task automatic test_freeze_at_wrap();
    logic [1:0] fc0;
    vga_t hold;
    en = 1'b1;
    for (int i = 0; i < 2 * SFT && (t % SFT != SFT - 1); i++) tick();
    checks++;
    if (vo_s.hcount !== 11'(SHT - 1) || vo_s.vcount !== 11'(SVT - 1)) begin
      errs++; $display("FAIL freeze_reach: at (%0d,%0d) want (%0d,%0d)",
                       vo_s.hcount, vo_s.vcount, SHT - 1, SVT - 1);
    end
    hold = ref_s(t);
    fc0  = 2'((t / SFT) % 4);
    en = 1'b0;
    repeat (50) begin
      tick();
      checks++;
      if ({vo_s, fs_s, fc_s} !== {hold, 1'b0, fc0}) begin
        errs++; $display("FAIL freeze_hold: got %h/%b/%0d want %h/0/%0d", vo_s, fs_s, fc_s, hold, fc0);
      end
    end
    en = 1'b1;
    tick();
    checks++;
    if (vo_s.hcount !== 11'd0 || vo_s.vcount !== 11'd0 || fs_s !== 1'b1 || fc_s !== fc0 + 2'd1) begin
      errs++; $display("FAIL freeze_resume: (%0d,%0d) fs=%b fc=%0d want (0,0) 1 %0d",
                       vo_s.hcount, vo_s.vcount, fs_s, fc_s, fc0 + 2'd1);
    end
  endtask

  task automatic test_frame_cnt_wrap();
    logic [1:0] seen[$];
    logic [1:0] want [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    reset_dut();
    repeat (5 * SFT + 5) begin
      tick();
      if (fs_s) seen.push_back(fc_s);
    end
    checks++;
    if (seen.size() != 5) begin
      errs++; $display("FAIL fc_wrap_count: got %0d strobes want 5", seen.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (seen[i] !== want[i]) begin
          errs++; $display("FAIL fc_wrap[%0d]: got %0d want %0d", i, seen[i], want[i]);
        end
      end
    end
  endtask

`ifdef VGA_TIMING_TEST_PATTERN_EN
  task automatic test_pattern();
    logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                              12'hF0F, 12'hF00, 12'h00F, 12'h000};
    logic [11:0] ws, wf;
    int hs, vs, hf, vf;
    reset_dut();
    repeat (SFT + 30) begin
      tick();
      hs = int'(t % SHT); vs = int'((t / SHT) % SVT);
      hf = int'(t % FHT); vf = int'((t / FHT) % FVT);
      ws = (hs >= SHA || vs >= SVA) ? 12'h000 : bars[hs / (SHA / 8)];
      wf = (hf >= 800 || vf >= 600) ? 12'h000 : bars[hf / 100];
      checks++;
      if (rgb_s !== ws || rgb_f !== wf) begin
        errs++; $display("FAIL pattern: t=%0d got %h/%h want %h/%h", t, rgb_s, rgb_f, ws, wf);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_random();
    test_freeze_at_wrap();
    test_frame_cnt_wrap();
`ifdef VGA_TIMING_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
